// File: rtl/ecpa_pkg.sv
// ============================================================================
// Module   : ecpa_pkg
// Brief    : Shared types and default sizes for the ECPA modular arithmetic units.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ecpa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        ADD  = 2'd2
    } fsm_state_t;

    localparam int LIMB_W_DEF = 64;
    localparam int WIDTH_DEF  = 256;

endpackage

`default_nettype wire

// File: rtl/limb_adder.sv
// ============================================================================
// Module   : limb_adder
// Brief    : Combinational LIMB_W-bit adder with carry-in and carry-out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module limb_adder #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              ci,
    output logic [LIMB_W-1:0] s,
    output logic              co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, ci};

endmodule

`default_nettype wire

// File: rtl/modular_subtraction.sv
// ============================================================================
// Module   : modular_subtraction
// Brief    : Limb-serial constant-time (A - B) mod p, subtract pass then
//            conditional add-back of p, fixed 2*N_LIMBS cycle latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module modular_subtraction
    import ecpa_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int LIMB_W = LIMB_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int N_LIMBS = WIDTH / LIMB_W;
    localparam int CNT_W   = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(N_LIMBS - 1);

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] limb_cnt_q, limb_cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    int               limb_lo;
    logic [LIMB_W-1:0] add_a, add_b, add_s;
    logic              add_co;

    assign limb_lo = int'(limb_cnt_q) * LIMB_W;

    // One shared carry chain: minuend/~subtrahend in SUB, work/masked p in ADD.
    always_comb begin
        add_a = a_q[limb_lo +: LIMB_W];
        add_b = ~b_q[limb_lo +: LIMB_W];
        if (state_q == ADD) begin
            add_a = work_q[limb_lo +: LIMB_W];
            add_b = p_q[limb_lo +: LIMB_W] & {LIMB_W{borrow_q}};
        end
    end

    limb_adder #(
        .LIMB_W (LIMB_W)
    ) u_limb_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d    = state_q;
        limb_cnt_d = limb_cnt_q;
        carry_d    = carry_q;
        borrow_d   = borrow_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        work_d     = work_q;
        result_d   = result_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d        = A;
                    b_d        = B;
                    p_d        = p;
                    limb_cnt_d = '0;
                    carry_d    = 1'b1;
                    state_d    = SUB;
                end
            end
            SUB: begin
                work_d[limb_lo +: LIMB_W] = add_s;
                carry_d    = add_co;
                limb_cnt_d = limb_cnt_q + CNT_W'(1);
                if (limb_cnt_q == LAST_LIMB) begin
                    // No carry out of A + ~B + 1 means A < B.
                    borrow_d   = ~add_co;
                    carry_d    = 1'b0;
                    limb_cnt_d = '0;
                    state_d    = ADD;
                end
            end
            ADD: begin
                work_d[limb_lo +: LIMB_W] = add_s;
                carry_d    = add_co;
                limb_cnt_d = limb_cnt_q + CNT_W'(1);
                if (limb_cnt_q == LAST_LIMB) begin
                    result_d   = work_d;
                    done_d     = 1'b1;
                    carry_d    = 1'b0;
                    limb_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            limb_cnt_q <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            work_q     <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            limb_cnt_q <= limb_cnt_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            work_q     <= work_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_modular_subtraction.sv
// ============================================================================
// Module   : tb_modular_subtraction
// Brief    : Self-checking bench for modular_subtraction (vectors, random, corners).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_modular_subtraction;

    localparam logic [255:0] PRIME =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int LATENCY = 8;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic [255:0] A, B, p;
    logic [255:0] result;
    logic         done;
    logic         busy;

    int n_cmp;
    int n_err;

    modular_subtraction #(
        .WIDTH  (256),
        .LIMB_W (64)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .A       (A),
        .B       (B),
        .p       (p),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    // Reference: the mathematical definition, including the out-of-range case.
    function automatic logic [255:0] ref_model(input logic [255:0] a, b, m);
        logic [256:0] t;
        t = {1'b0, a} - {1'b0, b};
        if (a < b) t = t + {1'b0, m};
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts one op, waits for done with a bound; returns result and latency.
    task automatic do_op(input logic [255:0] a, b, m, output logic [255:0] r,
                         output int lat, output bit busy_ok);
        @(negedge i_clk);
        A = a; B = b; p = m; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge i_clk);
            #1;
            lat++;
        end
        r = result;
    endtask

    task automatic run_and_check(input string name, input logic [255:0] a, b, m,
                                 input logic [255:0] exp);
        logic [255:0] r;
        int lat;
        bit bok;
        do_op(a, b, m, r, lat, bok);
        check({name, " result"}, r, exp);
        check({name, " latency"}, 256'(lat), 256'(LATENCY));
        check({name, " busy"}, {255'd0, busy | ~bok}, 256'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [255:0] r, ra, rb, rm;
        int lat;
        bit bok;
        int seen_done;

        n_cmp = 0;
        n_err = 0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        A = '0; B = '0; p = PRIME;

        repeat (3) @(posedge i_clk);
        #1;
        check("reset result", result, 256'd0);
        check("reset done/busy", {254'd0, done, busy}, 256'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        vecs[0] = '{256'd5, 256'd3, 256'd2};
        vecs[1] = '{256'd3, 256'd5, PRIME - 256'd2};
        vecs[2] = '{256'h1234, 256'h1234, 256'd0};
        vecs[3] = '{256'd0, 256'd0, 256'd0};
        vecs[4] = '{256'd1 << 64, 256'd1, 256'hFFFFFFFF_FFFFFFFF};
        vecs[5] = '{256'd1 << 192, 256'd1, (256'd1 << 192) - 256'd1};
        vecs[6] = '{PRIME - 256'd1, 256'd0, PRIME - 256'd1};
        vecs[7] = '{256'd0, PRIME - 256'd1, 256'd1};
        for (int i = 0; i < 8; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, PRIME, vecs[i].exp);

        for (int i = 0; i < 30; i++) begin
            ra = rand256(); rb = rand256();
            if (ra >= PRIME) ra = ra - PRIME;
            if (rb >= PRIME) rb = rb - PRIME;
            if (i % 5 == 0) rb = ra;
            do_op(ra, rb, PRIME, r, lat, bok);
            check($sformatf("rand%0d", i), r, ref_model(ra, rb, PRIME));
        end
        for (int i = 0; i < 8; i++) begin
            ra = rand256(); rb = rand256(); rm = rand256();
            do_op(ra, rb, rm, r, lat, bok);
            check($sformatf("oor%0d", i), r, ref_model(ra, rb, rm));
        end

        // Start while busy is ignored and in-flight operands are latched.
        @(negedge i_clk);
        A = 256'd5; B = 256'd3; p = PRIME; i_start = 1'b1;
        @(posedge i_clk);
        #1 A = 256'd9; B = 256'd1;
        lat = 0;
        while (!done && lat < 20) begin
            i_start = (lat >= 1 && lat <= 5);
            @(posedge i_clk);
            #1;
            lat++;
        end
        i_start = 1'b0;
        check("busy-start result", result, 256'd2);
        check("busy-start latency", 256'(lat), 256'(LATENCY));
        // Back-to-back: start raised in the done cycle.
        A = 256'd9; B = 256'd1; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check("b2b result", result, 256'd8);
        check("b2b latency", 256'(lat), 256'(LATENCY));

        // Reset mid-operation.
        @(negedge i_clk);
        A = 256'd100; B = 256'd1; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        check("midreset result", result, 256'd0);
        check("midreset done/busy", {254'd0, done, busy}, 256'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge i_clk);
            #1 if (done) seen_done++;
        end
        check("midreset no done", 256'(seen_done), 256'd0);
        run_and_check("after reset", 256'd7, 256'd2, PRIME, 256'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
